// File: rtl/pulse_capture_pkg.sv
// Shared types and defaults for the pulse capture block.
package pulse_capture_pkg;

    localparam int unsigned CNT_W_DEF       = 24;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam logic [23:0] TIMEOUT_DEF     = 24'hFF_FFFF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMED      = 3'd1,
        WAIT_PULSE = 3'd2,
        IN_PULSE   = 3'd3,
        DONE       = 3'd4
    } capState_t;

    // True while a capture is in progress (armed or timing).
    function automatic logic isBusyState(input capState_t s);
        return (s == ARMED) || (s == WAIT_PULSE) || (s == IN_PULSE);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by an edge register; emits one-cycle
// rise and fall strobes aligned to the synchronised level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic iCLK,
    input  logic iRESETn,
    input  logic iIN,
    output logic oRISE,
    output logic oFALL
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   edgeReg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous input.
                always_ff @(posedge iCLK or negedge iRESETn) begin
                    if (!iRESETn) syncReg[gi] <= 1'b0;
                    else          syncReg[gi] <= iIN;
                end
            end else begin : g_chain
                // Further stages let metastability settle.
                always_ff @(posedge iCLK or negedge iRESETn) begin
                    if (!iRESETn) syncReg[gi] <= 1'b0;
                    else          syncReg[gi] <= syncReg[gi-1];
                end
            end
        end
    endgenerate

    // Previous synchronised level for edge detection.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) edgeReg <= 1'b0;
        else          edgeReg <= syncReg[SYNC_STAGES-1];
    end

    assign oRISE = syncReg[SYNC_STAGES-1] & ~edgeReg;
    assign oFALL = ~syncReg[SYNC_STAGES-1] & edgeReg;

endmodule

// File: rtl/pulse_capture.sv
// Trigger-to-pulse delay and pulse-width capture. Measures in iCLK cycles
// and holds the result until acknowledged.
// Build option PULSE_CAPTURE_AUTOARM_EN: acknowledge re-arms the capture
// directly instead of returning to idle.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter int unsigned      SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF)
) (
    input  logic             iCLK,
    input  logic             iRESETn,
    input  logic             iTRIG,
    input  logic             iPULSE,
    input  logic             iARM,
    input  logic             iACK,
    output logic             oBUSY,
    output logic             oVALID,
    output logic             oTIMEOUT,
    output logic [CNT_W-1:0] oDELAY,
    output logic [CNT_W-1:0] oWIDTH
);

    logic trigRise;
    logic unusedTrigFall;
    logic pulRise;
    logic pulFall;

    capState_t        stateReg,   stateNext;
    logic [CNT_W-1:0] cntReg,     cntNext;
    logic [CNT_W-1:0] delayReg,   delayNext;
    logic [CNT_W-1:0] widthReg,   widthNext;
    logic             timeoutReg, timeoutNext;

    logic [CNT_W-1:0] cntInc;
    logic [CNT_W-1:0] cntSat;
    logic             atLimit;

    // Both lines share the same synchroniser depth so latency cancels.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uTrigSync (
        .iCLK    (iCLK),
        .iRESETn (iRESETn),
        .iIN     (iTRIG),
        .oRISE   (trigRise),
        .oFALL   (unusedTrigFall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uPulseSync (
        .iCLK    (iCLK),
        .iRESETn (iRESETn),
        .iIN     (iPULSE),
        .oRISE   (pulRise),
        .oFALL   (pulFall)
    );

    // cntInc is the count including the current cycle; the timeout normally
    // stops the count first, saturation is a backstop against wrapping.
    assign cntInc  = cntReg + CNT_W'(1);
    assign cntSat  = (&cntReg) ? cntReg : cntInc;
    assign atLimit = (cntInc == TIMEOUT);

    // State, counter and held results.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            delayReg   <= '0;
            widthReg   <= '0;
            timeoutReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            delayReg   <= delayNext;
            widthReg   <= widthNext;
            timeoutReg <= timeoutNext;
        end
    end

    // Next-state and measurement update; completing strobes win over timeout.
    always_comb begin
        stateNext   = stateReg;
        cntNext     = cntReg;
        delayNext   = delayReg;
        widthNext   = widthReg;
        timeoutNext = timeoutReg;

        case (stateReg)
            IDLE: begin
                if (iARM) stateNext = ARMED;
            end

            ARMED: begin
                if (trigRise) begin
                    cntNext = '0;
                    if (pulRise) begin
                        delayNext = '0;
                        stateNext = IN_PULSE;
                    end else begin
                        // A pulse already high is ignored until its next rise.
                        stateNext = WAIT_PULSE;
                    end
                end
            end

            WAIT_PULSE: begin
                if (pulRise) begin
                    delayNext = cntInc;
                    cntNext   = '0;
                    stateNext = IN_PULSE;
                end else if (atLimit) begin
                    delayNext   = TIMEOUT;
                    widthNext   = '0;
                    timeoutNext = 1'b1;
                    stateNext   = DONE;
                end else begin
                    cntNext = cntSat;
                end
            end

            IN_PULSE: begin
                if (pulFall) begin
                    widthNext   = cntInc;
                    timeoutNext = 1'b0;
                    stateNext   = DONE;
                end else if (atLimit) begin
                    widthNext   = TIMEOUT;
                    timeoutNext = 1'b1;
                    stateNext   = DONE;
                end else begin
                    cntNext = cntSat;
                end
            end

            DONE: begin
                if (iACK) begin
`ifdef PULSE_CAPTURE_AUTOARM_EN
                    stateNext = ARMED;
`else
                    stateNext = IDLE;
`endif
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign oBUSY    = isBusyState(stateReg);
    assign oVALID   = (stateReg == DONE);
    assign oTIMEOUT = timeoutReg;
    assign oDELAY   = delayReg;
    assign oWIDTH   = widthReg;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed and randomised bench for pulse_capture with a shot-level model.
module tb_pulse_capture;
    import pulse_capture_pkg::*;

    localparam int unsigned  CW     = 24;
    localparam int unsigned  SS     = 2;
    localparam int           TMO    = 1000;
    localparam logic [CW-1:0] TMO_V = 24'd1000;

    logic          wClk     = 1'b0;
    logic          iRESETn  = 1'b0;
    logic          iTRIG    = 1'b0;
    logic          iPULSE   = 1'b0;
    logic          iARM     = 1'b0;
    logic          iACK     = 1'b0;
    logic          oBUSY;
    logic          oVALID;
    logic          oTIMEOUT;
    logic [CW-1:0] oDELAY;
    logic [CW-1:0] oWIDTH;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        int delay;
        int width;
        int to;
    } res_t;

    pulse_capture #(
        .CNT_W       (CW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TMO_V)
    ) dut (
        .iCLK     (wClk),
        .iRESETn  (iRESETn),
        .iTRIG    (iTRIG),
        .iPULSE   (iPULSE),
        .iARM     (iARM),
        .iACK     (iACK),
        .oBUSY    (oBUSY),
        .oVALID   (oVALID),
        .oTIMEOUT (oTIMEOUT),
        .oDELAY   (oDELAY),
        .oWIDTH   (oWIDTH)
    );

    always #5 wClk = ~wClk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wClk);
            #1;
        end
    endtask

    // Expected result of one shot: d = trigger-to-pulse-rise distance,
    // w = pulse width; either phase lasting TMO cycles ends by timeout.
    function automatic res_t model(input int d, input int w, input bit hasRise, input bit hasFall);
        res_t r;
        if (!hasRise || d >= TMO) begin
            r.delay = TMO; r.width = 0; r.to = 1;
        end else if (!hasFall || w >= TMO) begin
            r.delay = d; r.width = TMO; r.to = 1;
        end else begin
            r.delay = d; r.width = w; r.to = 0;
        end
        return r;
    endfunction

    task automatic armPulse();
        iARM = 1'b1;
        tick(1);
        iARM = 1'b0;
    endtask

    task automatic ackPulse();
        iACK = 1'b1;
        tick(1);
        iACK = 1'b0;
    endtask

    // Drives one shot; trigger rises at t=0, pulse rises at t=d and falls at
    // t=d+w. Optional early pulse (high before trigger, low at t=5) and a
    // second trigger at retrigAt. Returns the first cycle oVALID was seen.
    task automatic runShot(input int d, input int w, input bit hasRise, input bit hasFall,
                           input int trigLen, input bit preHigh, input int retrigAt,
                           output int validAt);
        int len;
        bit normal;
        normal  = hasRise && hasFall && (d < TMO) && (w < TMO);
        len     = normal ? (d + w + int'(SS) + 8) : (TMO + d + int'(SS) + 20);
        validAt = -1;
        for (int t = 0; t < len; t++) begin
            iTRIG  = (t < trigLen) || (retrigAt >= 0 && t >= retrigAt && t < retrigAt + trigLen);
            iPULSE = (preHigh && t < 5) ||
                     (hasRise && t >= d && (!hasFall || t < d + w));
            tick(1);
            if (oVALID === 1'b1 && validAt < 0) validAt = t + 1;
        end
        iTRIG  = 1'b0;
        iPULSE = 1'b0;
    endtask

    initial begin
        int   va;
        int   d;
        int   w;
        int   kind;
        bit   hr;
        bit   hf;
        res_t e;

        // Reset state
        tick(3);
        check("rst_busy",    oBUSY,    0);
        check("rst_valid",   oVALID,   0);
        check("rst_timeout", oTIMEOUT, 0);
        check("rst_delay",   oDELAY,   0);
        check("rst_width",   oWIDTH,   0);
        check("rst_state",   dut.stateReg, IDLE);
        iRESETn = 1'b1;
        tick(2);

        // Acknowledge in idle is ignored
        ackPulse();
        check("idle_ack_busy",  oBUSY,  0);
        check("idle_ack_valid", oVALID, 0);

        // Delay 100, width 40
        armPulse();
        check("arm_busy", oBUSY, 1);
        runShot(100, 40, 1, 1, 8, 0, -1, va);
        $display("shot d=100 w=40 -> delay=%0d width=%0d to=%0d validAt=%0d", oDELAY, oWIDTH, oTIMEOUT, va);
        check("s1_valid",   oVALID,   1);
        check("s1_delay",   oDELAY,   100);
        check("s1_width",   oWIDTH,   40);
        check("s1_timeout", oTIMEOUT, 0);
        check("s1_latency", va - 140, SS + 1);
        ackPulse();
        check("s1_ack_valid", oVALID, 0);
        check("s1_hold_delay", oDELAY, 100);

        // Reset mid-capture with trigger held high
        armPulse();
        iTRIG = 1'b1;
        tick(SS + 3);
        check("mid_busy", oBUSY, 1);
        #2 iRESETn = 1'b0;
        #1;
        check("mid_rst_busy",    oBUSY,    0);
        check("mid_rst_valid",   oVALID,   0);
        check("mid_rst_delay",   oDELAY,   0);
        check("mid_rst_width",   oWIDTH,   0);
        check("mid_rst_timeout", oTIMEOUT, 0);
        check("mid_rst_state",   dut.stateReg, IDLE);
        tick(2);
        iRESETn = 1'b1;
        tick(15);
        check("post_rst_busy",  oBUSY,  0);
        check("post_rst_valid", oVALID, 0);
        iTRIG = 1'b0;
        tick(5);
        $display("reset mid-capture -> busy=%0d valid=%0d", oBUSY, oVALID);

        // Trigger and pulse on the same cycle
        armPulse();
        runShot(0, 5, 1, 1, 8, 0, -1, va);
        $display("shot d=0 w=5 -> delay=%0d width=%0d to=%0d", oDELAY, oWIDTH, oTIMEOUT);
        check("s2_valid", oVALID, 1);
        check("s2_delay", oDELAY, 0);
        check("s2_width", oWIDTH, 5);
        check("s2_timeout", oTIMEOUT, 0);
        tick(3);
        ackPulse();

        // No pulse: delay timeout
        armPulse();
        runShot(0, 0, 0, 0, 5, 0, -1, va);
        $display("shot no pulse -> delay=%0d width=%0d to=%0d validAt=%0d", oDELAY, oWIDTH, oTIMEOUT, va);
        check("t1_valid",   oVALID,   1);
        check("t1_delay",   oDELAY,   TMO);
        check("t1_width",   oWIDTH,   0);
        check("t1_timeout", oTIMEOUT, 1);
        check("t1_latency", va, TMO + SS + 1);
        tick(5);
        ackPulse();

        // Pulse stuck high: width timeout
        armPulse();
        runShot(10, 0, 1, 0, 5, 0, -1, va);
        $display("shot stuck pulse -> delay=%0d width=%0d to=%0d", oDELAY, oWIDTH, oTIMEOUT);
        check("t2_valid",   oVALID,   1);
        check("t2_delay",   oDELAY,   10);
        check("t2_width",   oWIDTH,   TMO);
        check("t2_timeout", oTIMEOUT, 1);
        tick(5);
        ackPulse();

        // Pulse already high at trigger, plus a second trigger while waiting
        armPulse();
        iPULSE = 1'b1;
        tick(10);
        runShot(20, 3, 1, 1, 3, 1, 10, va);
        $display("shot prehigh retrig d=20 w=3 -> delay=%0d width=%0d to=%0d", oDELAY, oWIDTH, oTIMEOUT);
        check("p_valid",   oVALID,   1);
        check("p_delay",   oDELAY,   20);
        check("p_width",   oWIDTH,   3);
        check("p_timeout", oTIMEOUT, 0);
        tick(3);
        ackPulse();

        // Randomised shots against the model
        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 9);
            hr = 1'b1;
            hf = 1'b1;
            d  = $urandom_range(0, 600);
            w  = $urandom_range(1, 400);
            if (kind == 0) hr = 1'b0;
            else if (kind == 1) d = $urandom_range(TMO + 50, TMO + 300);
            else if (kind == 2) w = $urandom_range(TMO + 50, TMO + 200);
            e = model(d, w, hr, hf);
            armPulse();
            runShot(d, w, hr, hf, $urandom_range(1, 6), 0, -1, va);
            $display("rand %0d d=%0d w=%0d rise=%0d -> delay=%0d width=%0d to=%0d (exp %0d %0d %0d)",
                     i, d, w, hr, oDELAY, oWIDTH, oTIMEOUT, e.delay, e.width, e.to);
            check("r_valid",   oVALID,   1);
            check("r_delay",   oDELAY,   e.delay);
            check("r_width",   oWIDTH,   e.width);
            check("r_timeout", oTIMEOUT, e.to);
            tick(5);
            ackPulse();
            tick(2);
        end

        // Back-to-back shots with a single arm
        armPulse();
        runShot(50, 10, 1, 1, 4, 0, -1, va);
        check("a1_delay", oDELAY, 50);
        tick(3);
        ackPulse();
        tick(3);
        runShot(70, 10, 1, 1, 4, 0, -1, va);
        $display("second shot without arm -> valid=%0d delay=%0d", oVALID, oDELAY);
`ifdef PULSE_CAPTURE_AUTOARM_EN
        check("a2_valid", oVALID, 1);
        check("a2_delay", oDELAY, 70);
        check("a2_width", oWIDTH, 10);
        ackPulse();
        check("a2_rearm_busy", oBUSY, 1);
`else
        check("a2_valid", oVALID, 0);
        check("a2_delay", oDELAY, 50);
        check("a2_busy",  oBUSY,  0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
